fc_stream_loader: RTL and testbench
===================================

// Module: fc_stream_loader
// PURPOSE
//  Upstream feeder for fc_controller. Accepts one FC job as a byte stream with valid/ready:
//  inputs, then weights, then biases. Packs the bytes little-endian into 32-bit words in a local buffer.
//  Once a complete, correctly framed job is buffered, it replays it to fc_controller as one gap-free r_valid burst.
//  Holds off the next job until fc_controller has returned all result words (t_valid).
// PARAMETERS
//  IN_BYTES   8   input vector length in bytes (int8 elements); multiple of 4
//  OUT_BYTES  4   output vector length in bytes; multiple of 4
//  derived localparams: W_BYTES=IN_BYTES*OUT_BYTES, TOT_BYTES=IN_BYTES+W_BYTES+OUT_BYTES,
//  TOT_WORDS=TOT_BYTES/4 (11 at defaults), OUT_WORDS=OUT_BYTES/4 (1 at defaults)
// PORTS
//  clk          in   1   single clock, all logic on rising edge
//  rst          in   1   synchronous, active-high reset
//  s_valid      in   1   upstream byte valid
//  s_ready      out  1   loader can accept a byte
//  s_data       in   8   job byte: in0..inN-1, w0..wM-1, b0..bK-1 in that order
//  s_last       in   1   marks final byte of a job
//  fc_r_valid   out  1   to fc_controller.r_valid
//  fc_in_data   out  32  to fc_controller.in_data; byte 4k+j in bits [8j+7:8j] of word k
//  fc_t_valid   in   1   from fc_controller.t_valid; one cycle per result word
//  busy         out  1   high in BURST and WAIT_RES states
//  frame_err    out  1   one-cycle pulse on framing error
// BEHAVIOUR
//  Reset: state=FILL, byte_cnt=0, s_ready=1, fc_r_valid=0, fc_in_data=0, busy=0, frame_err=0.
//  Buffer contents are don't-care after reset. rst mid-burst aborts immediately; no partial completion.
//  Byte transfer occurs on s_valid & s_ready. s_ready=1 only in FILL and DRAIN.
//  States:
//   FILL:
//    - Each accepted byte is written to buf[byte_cnt>>2] lane byte_cnt[1:0]; byte_cnt increments.
//    - s_last with byte_cnt==TOT_BYTES-1: go to BURST and clear byte_cnt.
//    - s_last earlier: frame_err pulse, byte_cnt=0, stay in FILL; partial job discarded.
//    - Byte TOT_BYTES-1 accepted without s_last: frame_err pulse, go to DRAIN.
//   DRAIN: accept and discard bytes until s_last accepted, then go to FILL with byte_cnt=0.
//   BURST:
//    - fc_r_valid=1 for exactly TOT_WORDS consecutive cycles; fc_in_data=buf[0..TOT_WORDS-1] in order.
//    - Outputs are registered. The first word appears on the cycle after the final byte is accepted (latency 1).
//    - After the last word, go to WAIT_RES and drive fc_r_valid=0, fc_in_data=0.
//   WAIT_RES:
//    - Count cycles with fc_t_valid=1; after OUT_WORDS of them, return to FILL.
//    - s_ready rises on the cycle after the last t_valid beat.
//  fc_t_valid outside WAIT_RES is ignored.
//  A frame_err pulse and a state change may share a cycle; the pulse is registered, 1 cycle after the offending byte.
//  byte_cnt width: $clog2(TOT_BYTES+1). The word counter wraps only via explicit clear, never modulo.
// STRUCTURE
//  fc_defs.vh (shared with fc_controller): IN_BYTES/OUT_BYTES defaults, BYTE_SIZE=8, WORD_SIZE=32,
//  and state encodings FILL/DRAIN/BURST/WAIT_RES.
//  One sub-module: fc_word_buf, a TOT_WORDS x 32 register file with byte-lane write enable and a registered read port.
//  FSM, counters and the framing check stay in the top level.
// TESTING
//  1) Job 1 bytes 12 10 2a b4 ff 1a 53 bd, then weights 81 f0 1f b8 ..., biases ef 19 f2 73 (s_last on 73)
//     -> burst words 0xb42a1012, 0xbd531aff, 0xb81ff081 ... last 0x73f219ef.
//     fc_r_valid high 11 cycles; end-to-end fc out_data=0x7f02_13ec.
//  2) Job 2 (in 0e 06 f5 91 29 2e c3 21, bias c8 42 c4 4e) sent back-to-back with s_valid held high
//     -> s_ready=0 until job 1's t_valid beat; fc out_data=0x3480_faa6.
//  3) s_last on byte 20 -> frame_err 1 cycle, no fc_r_valid; a following good job 1 is processed correctly.
//  4) 44 bytes without s_last, then 3 junk bytes, the 3rd with s_last -> one frame_err, DRAIN; next job correct.
//  5) rst pulsed during burst word 5 -> next cycle fc_r_valid=0, s_ready=1; resent job 1 yields correct result.
//  6) Random s_valid gaps (50%) during fill -> burst still contiguous 11 cycles with identical words to test 1.

Source files
------------

// File: rtl/fc_stream_loader_pkg.sv
// Shared definitions for the FC job stream loader: default job geometry,
// data widths and the loader state encoding.
package fc_stream_loader_pkg;

    localparam int IN_BYTES_DEF  = 8;
    localparam int OUT_BYTES_DEF = 4;
    localparam int BYTE_SIZE     = 8;
    localparam int WORD_SIZE     = 32;
    localparam int LANES         = WORD_SIZE / BYTE_SIZE;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        DRAIN    = 2'd1,
        BURST    = 2'd2,
        WAIT_RES = 2'd3
    } ld_state_e;

endpackage

// File: rtl/fc_word_buf.sv
// Job word buffer: DEPTH x 32 register file with per-byte-lane writes and a
// registered read port that returns zero whenever no read is requested.
module fc_word_buf
    import fc_stream_loader_pkg::*;
#(
    parameter int DEPTH = 11,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [LANES-1:0]     wr_be,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [WORD_SIZE-1:0] rd_data
);

    logic [WORD_SIZE-1:0] mem [DEPTH];

    // Contents are not reset; a job always overwrites every byte before replay.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < LANES; j++) begin
                if (wr_be[j]) begin
                    mem[wr_addr][j*BYTE_SIZE +: BYTE_SIZE] <= wr_data[j*BYTE_SIZE +: BYTE_SIZE];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/fc_stream_loader.sv
// Byte-stream front end for fc_controller: buffers one framed job, replays it
// as a gap-free word burst, then waits for all result words before the next job.
//
//  state    | meaning
//  FILL     | accepting job bytes into the buffer
//  DRAIN    | discarding an overlong frame until its s_last
//  BURST    | replaying buffered words on fc_r_valid
//  WAIT_RES | counting fc_t_valid result beats
module fc_stream_loader
    import fc_stream_loader_pkg::*;
#(
    parameter int IN_BYTES  = IN_BYTES_DEF,
    parameter int OUT_BYTES = OUT_BYTES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [BYTE_SIZE-1:0] s_data,
    input  logic                 s_last,
    output logic                 fc_r_valid,
    output logic [WORD_SIZE-1:0] fc_in_data,
    input  logic                 fc_t_valid,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int W_BYTES   = IN_BYTES * OUT_BYTES;
    localparam int TOT_BYTES = IN_BYTES + W_BYTES + OUT_BYTES;
    localparam int TOT_WORDS = TOT_BYTES / LANES;
    localparam int OUT_WORDS = OUT_BYTES / LANES;
    localparam int BCW       = $clog2(TOT_BYTES + 1);
    localparam int WCW       = $clog2(TOT_WORDS + 1);
    localparam int RCW       = $clog2(OUT_WORDS + 1);
    localparam int AW        = $clog2(TOT_WORDS);

    ld_state_e      state, state_nxt;
    logic [BCW-1:0] byte_cnt, byte_cnt_nxt;
    logic [WCW-1:0] word_cnt, word_cnt_nxt;
    logic [RCW-1:0] res_left, res_left_nxt;
    logic           ferr_nxt;
    logic           r_valid_q;
    logic           accept;
    logic           at_end;
    logic           wr_en;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [LANES-1:0] wr_be;

    assign s_ready    = (state == FILL) || (state == DRAIN);
    assign busy       = (state == BURST) || (state == WAIT_RES);
    assign accept     = s_valid && s_ready;
    assign at_end     = (byte_cnt == BCW'(TOT_BYTES - 1));
    assign wr_be      = LANES'(1) << byte_cnt[1:0];
    assign fc_r_valid = r_valid_q;

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        word_cnt_nxt = word_cnt;
        res_left_nxt = res_left;
        ferr_nxt     = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = '0;
        case (state)
            FILL: begin
                if (accept) begin
                    wr_en        = 1'b1;
                    byte_cnt_nxt = byte_cnt + BCW'(1);
                    if (s_last) begin
                        byte_cnt_nxt = '0;
                        if (at_end) begin
                            // Word 0 is launched on the same edge that writes the last byte.
                            state_nxt    = BURST;
                            rd_en        = 1'b1;
                            word_cnt_nxt = WCW'(1);
                        end else begin
                            ferr_nxt = 1'b1;
                        end
                    end else if (at_end) begin
                        ferr_nxt     = 1'b1;
                        byte_cnt_nxt = '0;
                        state_nxt    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept && s_last) begin
                    state_nxt    = FILL;
                    byte_cnt_nxt = '0;
                end
            end
            BURST: begin
                if (word_cnt == WCW'(TOT_WORDS)) begin
                    state_nxt    = WAIT_RES;
                    word_cnt_nxt = '0;
                    res_left_nxt = RCW'(OUT_WORDS);
                end else begin
                    rd_en        = 1'b1;
                    rd_addr      = AW'(word_cnt);
                    word_cnt_nxt = word_cnt + WCW'(1);
                end
            end
            WAIT_RES: begin
                if (fc_t_valid) begin
                    if (res_left == RCW'(1)) begin
                        state_nxt    = FILL;
                        res_left_nxt = '0;
                    end else begin
                        res_left_nxt = res_left - RCW'(1);
                    end
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            res_left  <= '0;
            frame_err <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            byte_cnt  <= byte_cnt_nxt;
            word_cnt  <= word_cnt_nxt;
            res_left  <= res_left_nxt;
            frame_err <= ferr_nxt;
            r_valid_q <= rd_en;
        end
    end

    fc_word_buf #(
        .DEPTH (TOT_WORDS),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (AW'(byte_cnt >> 2)),
        .wr_be   (wr_be),
        .wr_data ({LANES{s_data}}),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (fc_in_data)
    );

endmodule

// File: tb/tb_fc_stream_loader.sv
// Directed bench for fc_stream_loader: good jobs, back-to-back jobs, short and
// overlong frames, reset during a burst and gappy input.
module tb_fc_stream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        fc_r_valid;
    logic [31:0] fc_in_data;
    logic        fc_t_valid;
    logic        busy;
    logic        frame_err;

    fc_stream_loader dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .fc_r_valid (fc_r_valid),
        .fc_in_data (fc_in_data),
        .fc_t_valid (fc_t_valid),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  job1 [44];
    logic [7:0]  job2 [44];
    logic [31:0] burst_q [$];
    int          burst_runs = 0;
    int          ferr_cnt = 0;
    logic        prev_rv = 1'b0;
    int          f0;

    always @(posedge clk) begin
        #1;
        if (fc_r_valid) begin
            burst_q.push_back(fc_in_data);
            if (!prev_rv) burst_runs++;
        end
        if (frame_err) ferr_cnt++;
        prev_rv = fc_r_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] get_byte(input int sel, input int i);
        if (sel == 1) return job1[i];
        if (sel == 2) return job2[i];
        return 8'(i) ^ 8'h5a;
    endfunction

    function automatic logic [31:0] exp_word(input int sel, input int k);
        return {get_byte(sel, 4*k+3), get_byte(sel, 4*k+2), get_byte(sel, 4*k+1), get_byte(sel, 4*k)};
    endfunction

    function automatic logic [31:0] q_at(input int k);
        if (k < burst_q.size()) return burst_q[k];
        return 32'hdead_beef;
    endfunction

    task automatic clear_mon();
        burst_q.delete();
        burst_runs = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int guard = 0;
        s_valid = 1'b1;
        s_data  = b;
        s_last  = last;
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) chk("s_ready_timeout", 32'(s_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_seq(input int sel, input int n, input int last_pos, input bit gaps, input bit hold);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(1) == 1) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            send_byte(get_byte(sel, i), i == last_pos);
        end
        if (!hold) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_burst();
        int guard = 0;
        while ((burst_q.size() < 11 || fc_r_valid) && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        chk("burst_len", 32'(burst_q.size()), 32'd11);
    endtask

    task automatic check_burst(input int sel, input string tag);
        chk({tag, "_runs"}, 32'(burst_runs), 32'd1);
        for (int k = 0; k < 11; k++)
            chk($sformatf("%s_w%0d", tag, k), q_at(k), exp_word(sel, k));
    endtask

    task automatic check_launch(input int sel, input string tag);
        chk({tag, "_lat_rv"}, 32'(fc_r_valid), 32'd1);
        chk({tag, "_lat_w0"}, fc_in_data, exp_word(sel, 0));
    endtask

    task automatic t_beat(input string tag);
        chk({tag, "_wait_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_wait_busy"}, 32'(busy), 32'd1);
        fc_t_valid = 1'b1;
        @(negedge clk);
        fc_t_valid = 1'b0;
        chk({tag, "_done_ready"}, 32'(s_ready), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] in1 [8]  = '{8'h12, 8'h10, 8'h2a, 8'hb4, 8'hff, 8'h1a, 8'h53, 8'hbd};
        logic [7:0] in2 [8]  = '{8'h0e, 8'h06, 8'hf5, 8'h91, 8'h29, 8'h2e, 8'hc3, 8'h21};
        logic [7:0] b1 [4]   = '{8'hef, 8'h19, 8'hf2, 8'h73};
        logic [7:0] b2 [4]   = '{8'hc8, 8'h42, 8'hc4, 8'h4e};
        logic [7:0] w1h [4]  = '{8'h81, 8'hf0, 8'h1f, 8'hb8};
        for (int i = 0; i < 8; i++) begin
            job1[i] = in1[i];
            job2[i] = in2[i];
        end
        for (int i = 0; i < 32; i++) begin
            job1[8+i] = (i < 4) ? w1h[i] : 8'(i*29 + 7);
            job2[8+i] = 8'(i*53 + 3);
        end
        for (int i = 0; i < 4; i++) begin
            job1[40+i] = b1[i];
            job2[40+i] = b2[i];
        end

        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; fc_t_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_r_valid", 32'(fc_r_valid), 32'd0);
        chk("rst_in_data", fc_in_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: good job, t_valid during BURST must be ignored
        clear_mon(); f0 = ferr_cnt;
        send_seq(1, 44, 43, 1'b0, 1'b0);
        check_launch(1, "t1");
        fc_t_valid = 1'b1;
        repeat (3) @(negedge clk);
        fc_t_valid = 1'b0;
        wait_burst();
        check_burst(1, "t1");
        chk("t1_w0_hand", q_at(0), 32'hb42a1012);
        chk("t1_w1_hand", q_at(1), 32'hbd531aff);
        chk("t1_w2_hand", q_at(2), 32'hb81ff081);
        chk("t1_w10_hand", q_at(10), 32'h73f219ef);
        chk("t1_post_rv", 32'(fc_r_valid), 32'd0);
        chk("t1_post_data", fc_in_data, 32'd0);
        t_beat("t1");
        chk("t1_no_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Test 2: job 2 presented back-to-back while job 1 is in flight
        clear_mon();
        send_seq(1, 44, 43, 1'b0, 1'b1);
        check_launch(1, "t2a");
        fork
            send_seq(2, 44, 43, 1'b0, 1'b0);
            begin
                wait_burst();
                check_burst(1, "t2a");
                chk("t2_hold_valid", 32'(s_valid), 32'd1);
                t_beat("t2a");
                clear_mon();
            end
        join
        check_launch(2, "t2b");
        wait_burst();
        check_burst(2, "t2b");
        chk("t2_w0_hand", q_at(0), 32'h91f5060e);
        chk("t2_w10_hand", q_at(10), 32'h4ec442c8);
        t_beat("t2b");

        // Test 3: early s_last on byte 20
        clear_mon(); f0 = ferr_cnt;
        send_seq(1, 20, 19, 1'b0, 1'b0);
        chk("t3_ferr_pulse", 32'(frame_err), 32'd1);
        @(negedge clk);
        chk("t3_ferr_clear", 32'(frame_err), 32'd0);
        chk("t3_no_rv", 32'(burst_q.size()), 32'd0);
        chk("t3_ready", 32'(s_ready), 32'd1);
        send_seq(1, 44, 43, 1'b0, 1'b0);
        check_launch(1, "t3");
        wait_burst();
        check_burst(1, "t3");
        t_beat("t3");
        chk("t3_ferr_count", 32'(ferr_cnt - f0), 32'd1);

        // Test 4: overlong frame, drained by junk ending in s_last
        clear_mon(); f0 = ferr_cnt;
        send_seq(1, 44, -1, 1'b0, 1'b0);
        chk("t4_ferr_pulse", 32'(frame_err), 32'd1);
        chk("t4_drain_ready", 32'(s_ready), 32'd1);
        chk("t4_drain_busy", 32'(busy), 32'd0);
        send_seq(0, 3, 2, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_ferr_count", 32'(ferr_cnt - f0), 32'd1);
        chk("t4_no_rv", 32'(burst_q.size()), 32'd0);
        send_seq(2, 44, 43, 1'b0, 1'b0);
        check_launch(2, "t4");
        wait_burst();
        check_burst(2, "t4");
        t_beat("t4");

        // Test 5: reset while word 5 is on the bus
        clear_mon();
        send_seq(1, 44, 43, 1'b0, 1'b0);
        for (int g = 0; g < 40 && burst_q.size() < 6; g++) @(negedge clk);
        chk("t5_pre_rv", 32'(fc_r_valid), 32'd1);
        chk("t5_pre_w5", fc_in_data, exp_word(1, 5));
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_rv", 32'(fc_r_valid), 32'd0);
        chk("t5_rst_ready", 32'(s_ready), 32'd1);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_data", fc_in_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_no_resume", 32'(fc_r_valid), 32'd0);
        clear_mon();
        send_seq(1, 44, 43, 1'b0, 1'b0);
        check_launch(1, "t5");
        wait_burst();
        check_burst(1, "t5");
        t_beat("t5");

        // Test 6: random input gaps, burst must stay contiguous
        clear_mon(); f0 = ferr_cnt;
        send_seq(1, 44, 43, 1'b1, 1'b0);
        check_launch(1, "t6");
        wait_burst();
        check_burst(1, "t6");
        t_beat("t6");
        chk("t6_no_ferr", 32'(ferr_cnt - f0), 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
